// File: rtl/decoder_in_stage.sv
// decoder_in_stage: synchronises and debounces the io_in pad bus and
// hands each newly accepted code to decoder_proj over valid/ready.
module decoder_in_stage #(
  parameter int WIDTH         = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 2) begin : g_chk_stable
    $error("STABLE_CYCLES must be at least 2");
  end
  if (STABLE_CYCLES > (2**CNT_W) - 1) begin : g_chk_cnt
    $error("STABLE_CYCLES does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_commit;
  logic [WIDTH-1:0] r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_drop;
  logic             r_valid;

  logic [WIDTH-1:0] w_sampled;
  logic             w_edge;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [WIDTH-1:0] w_commit_nxt;
  logic [WIDTH-1:0] w_code_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_drop_nxt;
  logic             w_valid_nxt;

  assign w_sampled = r_sync[SYNC_STAGES-1];
  assign w_edge    = (w_sampled != r_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sampled;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cand   <= '0;
      r_commit <= '0;
      r_code   <= '0;
      r_cnt    <= '0;
      r_drop   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_commit <= w_commit_nxt;
      r_code   <= w_code_nxt;
      r_cnt    <= w_cnt_nxt;
      r_drop   <= w_drop_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_commit_nxt = r_commit;
    w_code_nxt   = r_code;
    w_cnt_nxt    = r_cnt;
    w_drop_nxt   = r_drop;
    w_valid_nxt  = r_valid;
    unique case (r_state)
      S_IDLE: begin
        if (w_sampled != r_commit) begin
          w_cand_nxt  = w_sampled;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_sampled != r_cand) begin
          w_cand_nxt = w_sampled;
          w_cnt_nxt  = CNT_ONE;
        end else if (r_cnt == CNT_LAST) begin
          // a glitch that settled back to the old code is dropped silently
          if (r_cand == r_commit) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_code_nxt   = r_cand;
            w_commit_nxt = r_cand;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (w_edge && !(&r_drop)) begin
          w_drop_nxt = r_drop + CNT_ONE;
        end
        if (code_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign code_out   = r_code;
  assign code_valid = r_valid;
  assign busy       = (r_state != S_IDLE);
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_decoder_in_stage.sv
// tb_decoder_in_stage: scoreboard bench for decoder_in_stage.
// Expected codes are queued on drive and popped on each handshake.
module tb_decoder_in_stage;

  localparam int W  = 7;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  io_in;
  logic [W-1:0]  code_out;
  logic          code_valid;
  logic          code_ready;
  logic          busy;
  logic [CW-1:0] drop_cnt;

  int            n_chk = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_q[$];
  logic          prev_v = 1'b0;
  logic [W-1:0]  prev_code = '0;

  decoder_in_stage #(
    .WIDTH(W),
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4),
    .CNT_W(CW)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_in(io_in),
    .code_out(code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!code_valid && n < max);
    if (!code_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (code_valid && prev_v)
        chk("code_stable", 32'(code_out), 32'(prev_code));
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0)
          chk("unexpected_valid", 32'(code_out), 32'hFFFF_FFFF);
        else
          chk("hs_code", 32'(code_out), 32'(exp_q.pop_front()));
      end
      prev_v    = code_valid && !code_ready;
      prev_code = code_out;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    int   n;
    logic seen_v;
    logic seen_b;
    logic bad_c;
    rst_n      = 1'b0;
    io_in      = '0;
    code_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      io_in = (i % 2 == 0) ? 7'h7F : 7'h00;
      tick(1);
      chk("rst_code", 32'(code_out), 32'd0);
      chk("rst_valid", 32'(code_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
    end
    io_in = '0;
    rst_n = 1'b1;
    seen_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen_v |= code_valid;
    end
    chk("idle_no_valid", 32'(seen_v), 32'd0);

    code_ready = 1'b1;
    exp_q.push_back(7'h4E);
    io_in = 7'b1001110;
    tick(5);
    chk("clean_pre_valid", 32'(code_valid), 32'd0);
    chk("clean_busy", 32'(busy), 32'd1);
    tick(1);
    chk("clean_valid", 32'(code_valid), 32'd1);
    chk("clean_code", 32'(code_out), 32'h4E);
    tick(1);
    chk("clean_pulse_end", 32'(code_valid), 32'd0);
    chk("clean_busy_end", 32'(busy), 32'd0);

    rst_n = 1'b0;
    io_in = '0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    io_in = 7'h4E;
    tick(2);
    io_in = 7'h00;
    seen_v = 1'b0;
    seen_b = 1'b0;
    bad_c  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen_v |= code_valid;
      seen_b |= busy;
      bad_c  |= (code_out != 7'h00);
    end
    chk("glitch_no_valid", 32'(seen_v), 32'd0);
    chk("glitch_busy_pulse", 32'(seen_b), 32'd1);
    chk("glitch_code", 32'(bad_c), 32'd0);
    chk("glitch_idle", 32'(busy), 32'd0);

    for (int s = 0; s < 5; s++) begin
      io_in = (s % 2 == 0) ? 7'h4E : 7'h4F;
      tick(2);
    end
    exp_q.push_back(7'h4F);
    io_in = 7'h4F;
    wait_valid(20, n);
    chk("bounce_latency", 32'(n), 32'd6);
    chk("bounce_code", 32'(code_out), 32'h4F);
    tick(1);
    chk("bounce_done", 32'(code_valid), 32'd0);

    code_ready = 1'b0;
    exp_q.push_back(7'h4E);
    io_in = 7'h4E;
    wait_valid(20, n);
    chk("bp_latency", 32'(n), 32'd6);
    for (int v = 1; v <= 3; v++) begin
      io_in = 7'(v);
      tick(3);
      chk("bp_hold_valid", 32'(code_valid), 32'd1);
      chk("bp_hold_code", 32'(code_out), 32'h4E);
    end
    chk("bp_drop", 32'(drop_cnt), 32'd3);
    exp_q.push_back(7'h03);
    code_ready = 1'b1;
    tick(1);
    chk("bp_release", 32'(code_valid), 32'd0);
    wait_valid(20, n);
    chk("bp_second_latency", 32'(n), 32'd4);
    chk("bp_second_code", 32'(code_out), 32'h03);
    tick(1);
    chk("bp_drop_kept", 32'(drop_cnt), 32'd3);

    code_ready = 1'b0;
    exp_q.push_back(7'h4E);
    io_in = 7'h4E;
    wait_valid(20, n);
    chk("rst_hold_valid", 32'(code_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(code_valid), 32'd0);
    chk("rst_async_code", 32'(code_out), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_drop", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    exp_q.push_back(7'h4E);
    wait_valid(20, n);
    chk("post_rst_latency", 32'(n), 32'd6);
    for (int i = 0; i < 100; i++) begin
      io_in = (i % 2 == 0) ? 7'h4F : 7'h4E;
      tick(1);
    end
    tick(2);
    chk("sat_drop_100", 32'(drop_cnt), 32'd100);
    for (int i = 100; i < 300; i++) begin
      io_in = (i % 2 == 0) ? 7'h4F : 7'h4E;
      tick(1);
    end
    tick(3);
    chk("sat_drop_255", 32'(drop_cnt), 32'd255);
    chk("sat_hold_code", 32'(code_out), 32'h4E);
    code_ready = 1'b1;
    tick(6);
    chk("sat_drop_after_hs", 32'(drop_cnt), 32'd255);
    chk("sat_valid_end", 32'(code_valid), 32'd0);
    chk("sat_busy_end", 32'(busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_in_stage.md
Name: decoder_in_stage

Overview:
- Front-end stage directly upstream of decoder_proj.
- Takes the raw 7-bit io_in pad bus and synchronises it into the clock domain.
- Debounces it: a change is accepted only after STABLE_CYCLES consecutive identical samples.
- Presents each accepted new code to the decoder over a valid/ready handshake, holding it stable under backpressure and counting input edges ignored while held.

Parameters:
WIDTH, 7, width of the io_in code bus
SYNC_STAGES, 2, synchroniser flops per bit (minimum 2)
STABLE_CYCLES, 4, consecutive identical samples required to accept a code (minimum 2)
CNT_W, 8, width of the debounce counter and drop_cnt

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
io_in  input  WIDTH  raw pad inputs, asynchronous to clk
code_out  output  WIDTH  accepted code to decoder
code_valid  output  1  code_out holds a new accepted code
code_ready  input  1  decoder accepts code_out on a rising edge where valid&ready
busy  output  1  FSM not in IDLE
drop_cnt  output  CNT_W  saturating count of input edges ignored during HOLD

Behaviour:
- Reset (rst_n low, asynchronous): every flop clears immediately, including sync chain, sampled, candidate, committed, cnt, code_out, drop_cnt and FSM state.
  - Outputs during reset: code_out=0, code_valid=0, busy=0, drop_cnt=0, state=IDLE.
  - Reset asserted mid-operation abandons any SETTLE/HOLD, drops valid without a handshake and discards the pending code.
  - Release is synchronous to clk; operation resumes on the first edge after deassertion.
- Sync chain: SYNC_STAGES flops per bit. sampled = last stage. prev_sampled = sampled delayed one cycle, used for edge detection.
- Registers:
  - committed (WIDTH): last accepted code; reset 0.
  - candidate (WIDTH): code under test.
  - cnt (CNT_W): debounce counter.
- FSM, evaluated on each rising edge:
  - IDLE: if sampled != committed: candidate<=sampled, cnt<=1, go SETTLE. Otherwise stay.
  - SETTLE:
    - if sampled != candidate: candidate<=sampled, cnt<=1, stay (restart).
    - else if cnt == STABLE_CYCLES-1:
      - if candidate == committed (glitch returned to old value): go IDLE, no output.
      - else: code_out<=candidate, committed<=candidate, code_valid<=1, go HOLD.
    - else cnt<=cnt+1.
  - HOLD: code_valid=1 and code_out frozen.
    - If code_ready=1 at the edge: code_valid<=0, go IDLE.
    - Each edge where sampled != prev_sampled increments drop_cnt, saturating at 2^CNT_W-1.
    - Input changes are not debounced in HOLD. On return to IDLE, the current sampled value is compared against committed, so the final settled input is still captured.
- Latency: with a clean change and committed differing, code_valid rises after the (SYNC_STAGES+STABLE_CYCLES)th rising edge, counting the first edge whose sync stage 0 captures the new value. Defaults give the 6th edge.
- Handshake:
  - code_ready high in the first HOLD cycle gives a 1-cycle valid pulse.
  - Minimum spacing between two accepted codes is 1 IDLE cycle + STABLE_CYCLES edges.
  - code_out never changes while code_valid=1.
  - code_valid never deasserts without ready, except on reset.
- busy = (state != IDLE), combinational from state.
- Simultaneous events:
  - Ready and an input edge on the same HOLD edge: the handshake completes and drop_cnt still increments.
  - drop_cnt is not cleared by handshakes, only by reset.
- A change back to committed before acceptance produces no output. The counter is not allowed to wrap: STABLE_CYCLES <= 2^CNT_W-1 is a required elaboration check.

Test Plan:
- Reset check: hold rst_n=0 with io_in=7'h7F toggling -> code_out=0, code_valid=0, busy=0, drop_cnt=0 throughout. After release with io_in stable at 0 -> no valid ever.
- Clean code: io_in 0 -> 7'b1001110, code_ready=1 -> code_valid high exactly after the 6th edge for 1 cycle, code_out=7'h4E, busy back to 0 the next cycle, committed=7'h4E.
- Glitch reject: io_in 0 -> 7'h4E for 2 cycles, then back to 0 -> busy pulses, code_valid never asserts, code_out stays 0.
- Bounce restart: io_in toggles 7'h4E/7'h4F every 2 cycles for 10 cycles, then settles at 7'h4F -> one valid with code_out=7'h4F, STABLE_CYCLES edges after the last sampled change.
- Backpressure: code_ready=0 after 7'h4E is accepted; io_in changes 3 times (to 7'h01, 7'h02, 7'h03) during HOLD; then ready=1 -> code_out holds 7'h4E throughout, drop_cnt=3. A second valid follows with code_out=7'h03.
- Reset mid-HOLD and saturation: assert rst_n=0 asynchronously while valid=1 -> valid drops before the next edge. Separately, 300 ignored edges in HOLD -> drop_cnt=255.
